// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/byte_mask_ram.sv
// DEPTH x DATA storage array with synchronous byte-enable write and
// combinational read.
module byte_mask_ram #(
  parameter int unsigned DATA  = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA/8-1:0]   be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA-1:0]     wdata,
  output logic [DATA-1:0]     rdata
);

  logic [DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA / 8; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait LATENCY cycles, then
// read or byte-masked write with a one-cycle valid strobe.
// Optional MEM_RESP_MISALIGN_ERR_EN: non-word-aligned addresses return err.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA    = 32,
  parameter int unsigned ADDRESS = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                request,
  input  logic                we_re,
  input  logic [DATA/8-1:0]   mask,
  input  logic [ADDRESS-1:0]  address,
  input  logic [DATA-1:0]     data_in,
  output logic                ready,
  output logic                valid,
  output logic [DATA-1:0]     data_out,
  output logic                err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = DATA / 8;

  resp_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [BW-1:0]      mask_q;
  logic [ADDRESS-1:0] addr_q;
  logic [DATA-1:0]    wdata_q;

  logic               accept;
  logic               bad_range;
  logic               misalign;
  logic               fault;
  logic               ram_we;
  logic [AW-1:0]      word;
  logic [DATA-1:0]    rdata;

  assign ready  = (state_q == IDLE) || (state_q == RESP);
  assign accept = ready && request;

  // Upper address bits beyond the array must be zero, and the index must fit.
  assign word      = addr_q[AW+1:2];
  assign bad_range = ((addr_q >> (AW + 2)) != '0) || ({1'b0, word} >= (AW+1)'(DEPTH));

`ifdef MEM_RESP_MISALIGN_ERR_EN
  assign misalign = (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign fault    = bad_range || misalign;
  assign valid    = (state_q == RESP);
  assign err      = valid && fault;
  assign data_out = (valid && !we_q && !fault) ? rdata : '0;
  assign ram_we   = valid && we_q && !fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_re;
        mask_q  <= mask;
        addr_q  <= address;
        wdata_q <= data_in;
      end
    end
  end

  byte_mask_ram #(
    .DATA  (DATA),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (mask_q),
    .addr  (word),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule
